// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/stall controller for the iterative divider
// Latches DIV/DIVU operands, sequences the divider and returns HI/LO as a one-cycle write.
`timescale 1ns/1ps
module div_issue_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid_i,
  input  logic        ex_div_signed_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FLUSH} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_nx;
  logic             flush_cnt, flush_cnt_nx;
  logic             hilo_we_q, hilo_we_nx;
  logic             start_nx, annul_nx, signed_nx, timeout_nx;
  logic [31:0]      op1_nx, op2_nx, hi_nx, lo_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      flush_cnt     <= 1'b0;
      hilo_we_q     <= 1'b0;
      div_start_o   <= 1'b0;
      div_annul_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_nx;
      wd_cnt        <= wd_cnt_nx;
      flush_cnt     <= flush_cnt_nx;
      hilo_we_q     <= hilo_we_nx;
      div_start_o   <= start_nx;
      div_annul_o   <= annul_nx;
      div_signed_o  <= signed_nx;
      div_opdata1_o <= op1_nx;
      div_opdata2_o <= op2_nx;
      hi_o          <= hi_nx;
      lo_o          <= lo_nx;
      timeout_o     <= timeout_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wd_cnt_nx    = wd_cnt;
    flush_cnt_nx = flush_cnt;
    hilo_we_nx   = 1'b0;
    start_nx     = div_start_o;
    annul_nx     = 1'b0;
    signed_nx    = div_signed_o;
    op1_nx       = div_opdata1_o;
    op2_nx       = div_opdata2_o;
    hi_nx        = hi_o;
    lo_nx        = lo_o;
    timeout_nx   = 1'b0;
    stall_req_o  = 1'b0;

    case (state)
      IDLE: begin
        stall_req_o = ex_div_valid_i & ~flush_i;
        if (ex_div_valid_i && !flush_i) begin
          op1_nx    = ex_rs_i;
          op2_nx    = ex_rt_i;
          signed_nx = ex_div_signed_i;
          start_nx  = 1'b1;
          wd_cnt_nx = '0;
          state_nx  = RUN;
        end
      end
      RUN: begin
        stall_req_o = ~div_ready_i & ~flush_i;
        wd_cnt_nx   = wd_cnt + 1'b1;
        if (flush_i) begin
          start_nx     = 1'b0;
          annul_nx     = 1'b1;
          flush_cnt_nx = 1'b0;
          state_nx     = FLUSH;
        end else if (div_ready_i) begin
          hi_nx      = div_result_i[63:32];
          lo_nx      = div_result_i[31:0];
          start_nx   = 1'b0;
          hilo_we_nx = 1'b1;
          state_nx   = DONE;
        end else if (wd_cnt == WD_LAST) begin
          timeout_nx   = 1'b1;
          annul_nx     = 1'b1;
          start_nx     = 1'b0;
          flush_cnt_nx = 1'b0;
          state_nx     = FLUSH;
        end
      end
      DONE: begin
        // The next divide waits in EX until IDLE so the divider sees start low first.
        stall_req_o = ex_div_valid_i & ~flush_i;
        state_nx    = IDLE;
      end
      FLUSH: begin
        stall_req_o  = ex_div_valid_i & ~flush_i;
        start_nx     = 1'b0;
        flush_cnt_nx = 1'b1;
        if (flush_cnt) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A flush landing on the write cycle kills the HI/LO update.
  assign hilo_we_o = hilo_we_q & ~flush_i;

endmodule
